// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Parametrised Mealy serial-pattern detector with a runtime-loadable
//            pattern and per-cycle selection of overlapping or non-overlapping
//            detection. Define MATCH_CNT_EN to build the saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             y,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int              FILL_W      = (PAT_W <= 2) ? 1 : $clog2(PAT_W);
  localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;

  logic [PAT_W-1:0]  w_window;
  logic              w_armed;
  logic              w_hit;
  logic [FILL_W-1:0] w_fill_next;

  // Newest bit sits in the LSB, so the live bit completes the window.
  assign w_window = {r_hist, x};
  assign w_armed  = (r_fill == c_FILL_FULL);
  assign w_hit    = en & ~load & w_armed & (w_window == r_pat);

  assign y     = w_hit;
  assign armed = w_armed;

  // Non-overlapping hits discard the whole window so the next match needs
  // PAT_W fresh bits; otherwise fill climbs and saturates at PAT_W-1.
  always_comb begin
    w_fill_next = r_fill;
    if (w_hit && !overlap) begin
      w_fill_next = '0;
    end else if (!w_armed) begin
      w_fill_next = r_fill + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= '0;
      r_hist <= '0;
      r_fill <= '0;
    end else if (load) begin
      r_pat  <= pattern;
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_window[PAT_W-2:0];
      r_fill <= w_fill_next;
    end
  end

`ifdef MATCH_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Scoreboard bench driving a 3-bit and a 4-bit detector in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

`ifdef MATCH_CNT_EN
  localparam bit c_CNT_ON = 1'b1;
`else
  localparam bit c_CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, en, x, load, overlap;
  logic [2:0] pat3;
  logic [3:0] pat4;
  logic       y3, armed3, y4, armed4;
  logic [1:0] cnt3;
  logic [7:0] cnt4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern(pat3),
    .overlap(overlap), .y(y3), .armed(armed3), .match_cnt(cnt3)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern(pat4),
    .overlap(overlap), .y(y4), .armed(armed4), .match_cnt(cnt4)
  );

  typedef struct {
    logic        y0, a0, y1, a1;
    int unsigned c0, c1;
  } exp_t;

  exp_t sb[$];

  // Reference model state, index 0 = 3-bit detector, index 1 = 4-bit detector
  int unsigned m_pat[2], m_hist[2], m_fill[2], m_cnt[2];
  int unsigned c_w[2]    = '{3, 4};
  int unsigned c_cmax[2] = '{3, 255};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned msk(input int unsigned w);
    return int'((64'd1 << w) - 64'd1);
  endfunction

  // Drive one cycle of stimulus, push what the DUTs must show before the
  // next edge, then advance the model past that edge.
  task automatic step(input bit r, input bit e, input bit xb, input bit ld,
                      input bit [2:0] p3, input bit [3:0] p4, input bit ov);
    exp_t        ex;
    logic        ey[2], ea[2];
    int unsigned ec[2];
    int unsigned win, w, pv;
    bit          hit;
    @(posedge clk);
    #1;
    reset = r; en = e; x = xb; load = ld; pat3 = p3; pat4 = p4; overlap = ov;
    for (int i = 0; i < 2; i++) begin
      w   = c_w[i];
      pv  = (i == 0) ? 32'(p3) : 32'(p4);
      win = ((m_hist[i] << 1) | 32'(xb)) & msk(w);
      hit = e && !ld && (m_fill[i] == w - 1) && (win == m_pat[i]);
      ey[i] = hit;
      ea[i] = (m_fill[i] == w - 1);
      ec[i] = c_CNT_ON ? m_cnt[i] : 0;
      if (r) begin
        m_pat[i] = 0; m_hist[i] = 0; m_fill[i] = 0; m_cnt[i] = 0;
      end else if (ld) begin
        m_pat[i] = pv; m_hist[i] = 0; m_fill[i] = 0; m_cnt[i] = 0;
      end else if (e) begin
        m_hist[i] = win & msk(w - 1);
        if (hit && !ov) m_fill[i] = 0;
        else if (m_fill[i] < w - 1) m_fill[i]++;
        if (hit && m_cnt[i] < c_cmax[i]) m_cnt[i]++;
      end
    end
    ex.y0 = ey[0]; ex.a0 = ea[0]; ex.c0 = ec[0];
    ex.y1 = ey[1]; ex.a1 = ea[1]; ex.c1 = ec[1];
    sb.push_back(ex);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, pat3, pat4, overlap);
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      chk("y3",     64'(y3),     64'(ex.y0));
      chk("armed3", 64'(armed3), 64'(ex.a0));
      chk("cnt3",   64'(cnt3),   64'(ex.c0));
      chk("y4",     64'(y4),     64'(ex.y1));
      chk("armed4", 64'(armed4), 64'(ex.a1));
      chk("cnt4",   64'(cnt4),   64'(ex.c1));
    end
  end

  initial begin
    bit [7:0] s1, s2;
    reset = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; overlap = 1'b1;
    pat3 = '0; pat4 = '0;
    for (int i = 0; i < 2; i++) begin
      m_pat[i] = 0; m_hist[i] = 0; m_fill[i] = 0; m_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b1);
    @(negedge clk);
    chk("rst_armed3", 64'(armed3), 64'd0);
    chk("rst_cnt4",   64'(cnt4),   64'd0);

    // Overlapping 010 on 0,1,0,1,0
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 4'b0101, 1'b1);
    s1 = 8'b01010;
    for (int i = 4; i >= 0; i--) step(1'b0, 1'b1, s1[i], 1'b0, 3'b010, 4'b0101, 1'b1);
    idle();
    @(negedge clk);
    chk("t1_cnt3", 64'(cnt3), c_CNT_ON ? 64'd2 : 64'd0);

    // Non-overlapping 010 on 0,1,0,1,0,0,1,0
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 4'b0101, 1'b0);
    s1 = 8'b01010010;
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, s1[i], 1'b0, 3'b010, 4'b0101, 1'b0);
    idle();
    @(negedge clk);
    chk("t2_cnt3", 64'(cnt3), c_CNT_ON ? 64'd2 : 64'd0);

    // 1011 with an en=0 gap in the middle
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 4'b1011, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'b1011, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 4'b1011, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i[0], 1'b0, 3'b011, 4'b1011, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'b1011, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 4'b1011, 1'b1);
    @(negedge clk);
    chk("t3_y4", 64'(y4), 64'd1);

    // Mid-stream reload
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t4_load_y3", 64'(y3), 64'd0);
    s1 = 8'b0110;
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, s1[i], 1'b0, 3'b110, 4'b0000, 1'b1);
    idle();
    @(negedge clk);
    chk("t4_cnt3", 64'(cnt3), c_CNT_ON ? 64'd1 : 64'd0);

    // Build up count 5 on the 4-bit detector, then reset with load and en
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 4'b0000, 1'b1);
    idle();
    @(negedge clk);
    chk("t5_armed4", 64'(armed4), 64'd1);
    chk("t5_cnt4",   64'(cnt4),   c_CNT_ON ? 64'd5 : 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'b101, 4'b1111, 1'b1);
    idle();
    @(negedge clk);
    chk("t5_rst_armed4", 64'(armed4), 64'd0);
    chk("t5_rst_cnt4",   64'(cnt4),   64'd0);
    // Pattern register went to zero, not to the ignored load value
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 4'b1111, 1'b1);
    @(negedge clk);
    chk("t5_zero_pat_y4", 64'(y4), 64'd1);

    // Saturation on the 2-bit counter
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b1);
    idle();
    @(negedge clk);
    chk("t6_cnt3", 64'(cnt3), c_CNT_ON ? 64'd3 : 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s1 = 8'($urandom);
      s2 = 8'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), s1[7],
           ($urandom_range(0, 19) == 0), s2[2:0], s2[7:4], s1[0]);
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
